// File: rtl/dpr_op_pkg.sv
// Shared definitions for the dpr_op_engine datapath: opcode values, FSM states
// and the shift-amount width helper.
package dpr_op_pkg;

    localparam int OP_ADD = 0;
    localparam int OP_DEC = 1;
    localparam int OP_DIV = 2;
    localparam int OP_INC = 3;
    localparam int OP_MOD = 4;
    localparam int OP_MUL = 5;
    localparam int OP_MUX = 6;
    localparam int OP_REG = 7;
    localparam int OP_SHL = 8;
    localparam int OP_SHR = 9;
    localparam int OP_SUB = 10;

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_DIV  = 2'd1,
        ST_DONE = 2'd2
    } state_t;

    function automatic int shamt_w(input int width);
        return $clog2(width);
    endfunction

endpackage

// File: rtl/dpr_op_engine_if.sv
// Operand/result handshake bundle between the PS-side producer (master) and
// dpr_op_engine (slave).
interface dpr_op_engine_if #(
    parameter int DATAWIDTH = 16,
    parameter int OPW       = 5
);
    logic                 in_valid;
    logic                 in_ready;
    logic [DATAWIDTH-1:0] a;
    logic [DATAWIDTH-1:0] b;
    logic [OPW-1:0]       op_sel;
    logic                 mux_sel;
    logic                 out_valid;
    logic                 out_ready;
    logic [DATAWIDTH-1:0] out;
    logic                 comp_lt;
    logic                 comp_gt;
    logic                 comp_eq;
    logic                 div_zero;

    modport master (
        output in_valid, a, b, op_sel, mux_sel, out_ready,
        input  in_ready, out_valid, out, comp_lt, comp_gt, comp_eq, div_zero
    );

    modport slave (
        input  in_valid, a, b, op_sel, mux_sel, out_ready,
        output in_ready, out_valid, out, comp_lt, comp_gt, comp_eq, div_zero
    );
endinterface

// File: rtl/dpr_op_div.sv
// Restoring unsigned divider, one quotient bit per cycle. The first bit is
// resolved on the start edge so a W-bit division finishes W cycles after start.
module dpr_op_div #(
    parameter int W = 16
) (
    input  logic         clk,
    input  logic         rst,
    input  logic         abort,
    input  logic         start,
    input  logic [W-1:0] dividend,
    input  logic [W-1:0] divisor,
    output logic         busy,
    output logic         done,
    output logic [W-1:0] quot,
    output logic [W-1:0] rem
);
    localparam int CW = $clog2(W);

    logic [CW-1:0] cnt;
    logic [W-1:0]  rem_r, quot_r, dvs_r;
    logic [W-1:0]  rem_src, quot_src, dvs_src, rem_nxt;
    logic [W:0]    trial;
    logic          fits;

    assign rem_src  = start ? '0 : rem_r;
    assign quot_src = start ? dividend : quot_r;
    assign dvs_src  = start ? divisor : dvs_r;

    // Partial remainder stays below the divisor, so one extra bit covers the shift.
    assign trial   = {rem_src, quot_src[W-1]};
    assign fits    = trial >= {1'b0, dvs_src};
    assign rem_nxt = fits ? W'(trial - {1'b0, dvs_src}) : trial[W-1:0];

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            busy <= 1'b0;
            done <= 1'b0;
            cnt  <= '0;
        end else begin
            done <= 1'b0;
            if (abort) begin
                busy <= 1'b0;
            end else if (start) begin
                busy <= 1'b1;
                cnt  <= CW'(1);
            end else if (busy) begin
                cnt <= cnt + CW'(1);
                if (cnt == CW'(W - 1)) begin
                    busy <= 1'b0;
                    done <= 1'b1;
                end
            end
        end
    end

    always_ff @(posedge clk) begin
        if (start || busy) begin
            rem_r  <= rem_nxt;
            quot_r <= {quot_src[W-2:0], fits};
            dvs_r  <= dvs_src;
        end
    end

    assign quot = quot_r;
    assign rem  = rem_r;
endmodule

// File: rtl/dpr_op_engine.sv
// Handshaked op-select datapath with comparison flags and decouple abort.
// Define DPR_OP_ENGINE_DIV_EN to build the iterative DIV/MOD divider.
module dpr_op_engine
    import dpr_op_pkg::*;
#(
    parameter int DATAWIDTH = 16,
    parameter int OPW       = 5
) (
    input  logic           clk,
    input  logic           rst,
    input  logic           decouple,
    dpr_op_engine_if.slave bus
);
    localparam int SHW = shamt_w(DATAWIDTH);

    state_t               state;
    logic [DATAWIDTH-1:0] out_r, hist, res;
    logic                 lt_r, gt_r, eq_r, dz_r;
    logic                 lt_c, gt_c, eq_c, dz_c;
    logic                 accept, go_div;
    logic [SHW-1:0]       shamt;

    assign bus.in_ready  = (state == ST_IDLE) && !decouple;
    assign bus.out_valid = (state == ST_DONE);
    assign bus.out       = out_r;
    assign bus.comp_lt   = lt_r;
    assign bus.comp_gt   = gt_r;
    assign bus.comp_eq   = eq_r;
    assign bus.div_zero  = dz_r;

    assign accept = bus.in_valid && bus.in_ready;
    assign shamt  = bus.b[SHW-1:0];
    assign lt_c   = bus.a < bus.b;
    assign gt_c   = bus.a > bus.b;
    assign eq_c   = bus.a == bus.b;

    always_comb begin
        res  = '0;
        dz_c = 1'b0;
        case (int'(bus.op_sel))
            OP_ADD: res = bus.a + bus.b;
            OP_DEC: res = bus.a - DATAWIDTH'(1);
            OP_INC: res = bus.a + DATAWIDTH'(1);
            OP_MUL: res = bus.a * bus.b;
            OP_MUX: res = bus.mux_sel ? bus.b : bus.a;
            OP_REG: res = hist;
            OP_SHL: res = bus.a << shamt;
            OP_SHR: res = bus.a >> shamt;
            OP_SUB: res = bus.a - bus.b;
`ifdef DPR_OP_ENGINE_DIV_EN
            // Only the divide-by-zero outcome is resolved here; b != 0 goes to the divider.
            OP_DIV: begin res = '1;    dz_c = 1'b1; end
            OP_MOD: begin res = bus.a; dz_c = 1'b1; end
`else
            OP_DIV, OP_MOD: dz_c = 1'b1;
`endif
            default: res = '0;
        endcase
    end

`ifdef DPR_OP_ENGINE_DIV_EN
    logic                 div_busy, div_done;
    logic                 pend_mod, pend_lt, pend_gt, pend_eq;
    logic [DATAWIDTH-1:0] quot, rem;

    assign go_div = accept && (bus.b != '0) &&
                    (int'(bus.op_sel) == OP_DIV || int'(bus.op_sel) == OP_MOD);

    dpr_op_div #(.W(DATAWIDTH)) u_div (
        .clk      (clk),
        .rst      (rst),
        .abort    (decouple),
        .start    (go_div),
        .dividend (bus.a),
        .divisor  (bus.b),
        .busy     (div_busy),
        .done     (div_done),
        .quot     (quot),
        .rem      (rem)
    );

    // Flags are parked here so the visible flag outputs only change on entry to DONE.
    always_ff @(posedge clk) begin
        if (go_div) begin
            pend_mod <= (int'(bus.op_sel) == OP_MOD);
            pend_lt  <= lt_c;
            pend_gt  <= gt_c;
            pend_eq  <= eq_c;
        end
    end
`else
    assign go_div = 1'b0;
`endif

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state <= ST_IDLE;
            out_r <= '0;
            lt_r  <= 1'b0;
            gt_r  <= 1'b0;
            eq_r  <= 1'b0;
            dz_r  <= 1'b0;
            hist  <= '0;
        end else if (decouple) begin
            state <= ST_IDLE;
        end else begin
            case (state)
                ST_IDLE: begin
                    if (accept) begin
                        if (go_div) begin
                            state <= ST_DIV;
                        end else begin
                            state <= ST_DONE;
                            out_r <= res;
                            lt_r  <= lt_c;
                            gt_r  <= gt_c;
                            eq_r  <= eq_c;
                            dz_r  <= dz_c;
                        end
                    end
                end
`ifdef DPR_OP_ENGINE_DIV_EN
                ST_DIV: begin
                    if (div_done && !div_busy) begin
                        state <= ST_DONE;
                        out_r <= pend_mod ? rem : quot;
                        lt_r  <= pend_lt;
                        gt_r  <= pend_gt;
                        eq_r  <= pend_eq;
                        dz_r  <= 1'b0;
                    end
                end
`endif
                ST_DONE: begin
                    if (bus.out_ready) begin
                        state <= ST_IDLE;
                        hist  <= out_r;
                    end
                end
                default: state <= ST_IDLE;
            endcase
        end
    end
endmodule
